// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: turns the raw PLL lock into a clean system reset.
// Ports: clock/reset (sync, active-high), pll_locked (async raw lock),
//   clear_lost (pulse), sys_reset/ready (registered, complementary),
//   lost_sticky, lock_loss_count (saturating), state (debug encoding).
module pll_reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 4096,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int COUNT_W            = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pll_locked,
   input  logic               clear_lost,
   output logic               sys_reset,
   output logic               ready,
   output logic               lost_sticky,
   output logic [COUNT_W-1:0] lock_loss_count,
   output logic [2:0]         state
);

   localparam int MAX_C = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                          LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABLE    = 3'd1,
      HOLD      = 3'd2,
      RUN       = 3'd3,
      LOST      = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sync1_q, sync1_d;
   logic               sync2_q, sync2_d;
   logic               sys_reset_q, sys_reset_d;
   logic               ready_q, ready_d;
   logic               sticky_q, sticky_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               locked_s;

   assign locked_s = sync2_q;

   always_comb begin
      sync1_d  = pll_locked;
      sync2_d  = sync1_q;
      state_d  = state_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      count_d  = count_q;

      if (clear_lost) begin
         sticky_d = 1'b0;
         count_d  = '0;
      end

      case (state_q)
         WAIT_LOCK: begin
            cnt_d = '0;
            if (locked_s) state_d = STABLE;
         end
         STABLE: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            // A loss overrides a simultaneous clear_lost
            if (!locked_s) begin
               state_d  = LOST;
               sticky_d = 1'b1;
               if (clear_lost)
                  count_d = COUNT_W'(1);
               else if (count_q != '1)
                  count_d = count_q + COUNT_W'(1);
            end
         end
         LOST: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase

      // Registered from next state so outputs change with the state
      sys_reset_d = (state_d != RUN);
      ready_d     = (state_d == RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= WAIT_LOCK;
         cnt_q       <= '0;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         sticky_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sys_reset_q <= sys_reset_d;
         ready_q     <= ready_d;
         sticky_q    <= sticky_d;
         count_q     <= count_d;
      end
   end

   assign sys_reset       = sys_reset_q;
   assign ready           = ready_q;
   assign lost_sticky     = sticky_q;
   assign lock_loss_count = count_q;
   assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed scenarios plus random lock traffic,
// compared every cycle against a lock-streak reference model.
module tb_pll_reset_sequencer;

   localparam int L     = 4;
   localparam int H     = 8;
   localparam int W     = 2;
   localparam int MAXC  = (1 << W) - 1;

   logic         clock = 1'b0;
   logic         reset;
   logic         pll_locked;
   logic         clear_lost;
   logic         sys_reset;
   logic         ready;
   logic         lost_sticky;
   logic [W-1:0] lock_loss_count;
   logic [2:0]   state;

   int checks = 0;
   int errors = 0;

   // Reference model: lock seen by the FSM lags the pin by two edges.
   // k = consecutive locked observations since the sequence (re)started.
   bit p1, p2;
   int k;
   bit lostp;
   bit m_sticky;
   int m_count;

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(L),
      .RESET_HOLD_CYCLES (H),
      .COUNT_W           (W)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .pll_locked     (pll_locked),
      .clear_lost     (clear_lost),
      .sys_reset      (sys_reset),
      .ready          (ready),
      .lost_sticky    (lost_sticky),
      .lock_loss_count(lock_loss_count),
      .state          (state)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_state();
      if (lostp)      return 4;
      if (k == 0)     return 0;
      if (k <= L)     return 1;
      if (k <= L + H) return 2;
      return 3;
   endfunction

   task automatic step(input bit lk, input bit clr, input bit rst);
      bit ls;
      pll_locked = lk;
      clear_lost = clr;
      reset      = rst;
      @(posedge clock);
      if (rst) begin
         p1 = 0; p2 = 0; k = 0; lostp = 0; m_sticky = 0; m_count = 0;
      end else begin
         ls = p2;
         p2 = p1;
         p1 = lk;
         if (clr) begin
            m_sticky = 0;
            m_count  = 0;
         end
         if (lostp) begin
            lostp = 0;
            k     = 0;
         end else if (k > L + H) begin
            if (!ls) begin
               lostp    = 1;
               k        = 0;
               m_sticky = 1;
               m_count  = (m_count >= MAXC) ? MAXC : m_count + 1;
            end
         end else begin
            k = ls ? k + 1 : 0;
         end
      end
      #1;
      chk("state", 32'(state), 32'(exp_state()));
      chk("sys_reset", 32'(sys_reset), 32'(exp_state() != 3));
      chk("ready", 32'(ready), 32'(exp_state() == 3));
      chk("sticky", 32'(lost_sticky), 32'(m_sticky));
      chk("count", 32'(lock_loss_count), 32'(m_count));
   endtask

   // Edges until sys_reset first reads low, lock held; 0 if never
   task automatic measure_release(output int rel);
      rel = 0;
      for (int n = 1; n <= 40; n++) begin
         step(1'b1, 1'b0, 1'b0);
         if (rel == 0 && sys_reset == 1'b0) rel = n;
      end
   endtask

   task automatic lose_lock();
      for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int rel;
      int hi, lo;
      pll_locked = 1'b0;
      clear_lost = 1'b0;
      reset      = 1'b1;

      // 1: reset, no lock
      repeat (3) step(1'b0, 1'b0, 1'b1);
      repeat (50) step(1'b0, 1'b0, 1'b0);
      chk("idle_state", 32'(state), 32'd0);

      // 2: first release latency
      measure_release(rel);
      chk("release_edge", 32'(rel), 32'd15);
      chk("run_state", 32'(state), 32'd3);

      // 3: loss from RUN
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("loss_e2_sysrst", 32'(sys_reset), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      chk("loss_e3_sysrst", 32'(sys_reset), 32'd1);
      chk("loss_e3_state", 32'(state), 32'd4);
      step(1'b0, 1'b0, 1'b0);
      chk("loss_e4_state", 32'(state), 32'd0);
      chk("loss_count", 32'(lock_loss_count), 32'd1);
      measure_release(rel);
      chk("relock_edge", 32'(rel), 32'd15);

      // 4: drop during STABLE is not a loss and restarts the sequence
      lose_lock();
      step(1'b0, 1'b1, 1'b0);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      chk("in_stable", 32'(state), 32'd1);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk("stable_drop_state", 32'(state), 32'd0);
      chk("stable_drop_cnt", 32'(lock_loss_count), 32'd0);
      measure_release(rel);
      chk("restart_edge", 32'(rel), 32'd15);

      // 5: saturation, clear, clear colliding with a loss
      for (int i = 0; i < 4; i++) begin
         lose_lock();
         measure_release(rel);
      end
      chk("sat_count", 32'(lock_loss_count), 32'd3);
      step(1'b1, 1'b1, 1'b0);
      chk("clr_count", 32'(lock_loss_count), 32'd0);
      chk("clr_sticky", 32'(lost_sticky), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("clr_loss_count", 32'(lock_loss_count), 32'd1);
      chk("clr_loss_sticky", 32'(lost_sticky), 32'd1);

      // 6: reset during HOLD
      step(1'b0, 1'b0, 1'b0);
      repeat (10) step(1'b1, 1'b0, 1'b0);
      chk("in_hold", 32'(state), 32'd2);
      step(1'b1, 1'b0, 1'b1);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_sysrst", 32'(sys_reset), 32'd1);
      chk("rst_count", 32'(lock_loss_count), 32'd0);
      chk("rst_sticky", 32'(lost_sticky), 32'd0);
      measure_release(rel);
      chk("post_rst_edge", 32'(rel), 32'd15);

      // Random lock traffic with sporadic clears and resets
      repeat (150) begin
         hi = $urandom_range(1, 24);
         lo = $urandom_range(1, 5);
         repeat (hi) step(1'b1, ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 199) == 0));
         repeat (lo) step(1'b0, ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 199) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
